audio_codec_i2s: RTL and testbench

AUDIO_CODEC_I2S -- requirements
Module: audio_codec_i2s

---
 rtl/audio_codec_i2s.sv | 262 ++++++++++++++++++++++++++
 tb/tb_audio_codec_i2s.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_codec_i2s.sv
// audio_codec_i2s
//   I2S bridge between a codec that masters BCLK/LRCK and Avalon-ST sample
//   streams. The codec pins are synchronized into i_clk. Strobes for the
//   BCLK edges drive a capture FSM for the ADC and a playback FSM for the DAC.
//   Frame clocks: low = left channel, high = right channel.
// Ports
//   i_clk, i_rst                      system clock, synchronous active-high reset
//   i_AUD_BCLK                        codec bit clock (async)
//   i_AUD_ADCLRCK, i_AUD_DACLRCK      ADC / DAC frame clocks (async)
//   i_AUD_ADCDAT, o_AUD_DACDAT        serial ADC input, serial DAC output
//   adc_{left,right}_{data,valid,ready}  captured-sample sources
//   dac_{left,right}_{data,valid,ready}  playback-sample sinks
//   o_adc_overrun, o_dac_underrun     one-cycle event pulses
module audio_codec_i2s #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_AUD_BCLK,
  input  logic              i_AUD_ADCLRCK,
  input  logic              i_AUD_DACLRCK,
  input  logic              i_AUD_ADCDAT,
  output logic              o_AUD_DACDAT,
  output logic [DATA_W-1:0] adc_left_data,
  output logic [DATA_W-1:0] adc_right_data,
  output logic              adc_left_valid,
  output logic              adc_right_valid,
  input  logic              adc_left_ready,
  input  logic              adc_right_ready,
  input  logic [DATA_W-1:0] dac_left_data,
  input  logic [DATA_W-1:0] dac_right_data,
  input  logic              dac_left_valid,
  input  logic              dac_right_valid,
  output logic              dac_left_ready,
  output logic              dac_right_ready,
  output logic              o_adc_overrun,
  output logic              o_dac_underrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // The ADC counter holds the index of the last captured bit; the final bit
  // arrives while it reads DATA_W-2.
  localparam logic [CNT_W-1:0] ADC_LAST = CNT_W'(DATA_W - 2);
  localparam logic [CNT_W-1:0] DAC_LAST = CNT_W'(DATA_W);

  localparam logic [1:0] ADC_WAIT  = 2'd0;
  localparam logic [1:0] ADC_SKIP  = 2'd1;
  localparam logic [1:0] ADC_SHIFT = 2'd2;
  localparam logic [0:0] DAC_IDLE  = 1'b0;
  localparam logic [0:0] DAC_SHIFT = 1'b1;

  // ---------------------------------------------------------------- sync
  logic [3:0] sync_r [SYNC_STAGES];
  logic       bclk_prev_r;
  logic       bclk_s, adclrck_s, daclrck_s, adcdat_s;
  logic       bclk_rise_s, bclk_fall_s;

  // Pin synchronizers plus previous BCLK; free-running so no false edge appears at reset release.
  always_ff @(posedge i_clk) begin
    sync_r[0] <= {i_AUD_BCLK, i_AUD_ADCLRCK, i_AUD_DACLRCK, i_AUD_ADCDAT};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_r[i] <= sync_r[i-1];
    end
    bclk_prev_r <= bclk_s;
  end

  assign bclk_s      = sync_r[SYNC_STAGES-1][3];
  assign adclrck_s   = sync_r[SYNC_STAGES-1][2];
  assign daclrck_s   = sync_r[SYNC_STAGES-1][1];
  assign adcdat_s    = sync_r[SYNC_STAGES-1][0];
  assign bclk_rise_s = bclk_s & ~bclk_prev_r;
  assign bclk_fall_s = ~bclk_s & bclk_prev_r;

  // ---------------------------------------------------------------- ADC
  logic [1:0]        adc_state_r;
  logic              adc_lrck_r;
  logic              adc_chan_r;
  logic [CNT_W-1:0]  adc_cnt_r;
  logic [DATA_W-2:0] adc_shift_r;
  logic              adc_edge_s, adc_done_s;
  logic [DATA_W-1:0] adc_word_s;
  logic [DATA_W-1:0] adc_l_data_r, adc_r_data_r;
  logic              adc_l_valid_r, adc_r_valid_r, adc_ovr_r;

  assign adc_edge_s = bclk_rise_s & (adclrck_s ^ adc_lrck_r);
  assign adc_done_s = bclk_rise_s & ~adc_edge_s & (adc_state_r == ADC_SHIFT) &
                      (adc_cnt_r == ADC_LAST);
  assign adc_word_s = {adc_shift_r, adcdat_s};

  // ADC capture FSM; a frame edge always restarts at SKIP, dropping any partial word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      adc_state_r <= ADC_WAIT;
      adc_lrck_r  <= adclrck_s;  // only a transition after release starts a frame
      adc_chan_r  <= 1'b0;
      adc_cnt_r   <= CNT_ZERO;
      adc_shift_r <= {(DATA_W-1){1'b0}};
    end else begin
      if (bclk_rise_s) begin
        adc_lrck_r <= adclrck_s;
      end
      if (adc_edge_s) begin
        adc_state_r <= ADC_SKIP;
        adc_chan_r  <= adclrck_s;
        adc_cnt_r   <= CNT_ZERO;
        adc_shift_r <= {(DATA_W-1){1'b0}};
      end else if (bclk_rise_s) begin
        case (adc_state_r)
          ADC_WAIT: begin
            adc_state_r <= ADC_WAIT;
          end
          // The edge rise carried the previous word's LSB; this rise carries the MSB.
          ADC_SKIP: begin
            adc_shift_r <= {adc_shift_r[DATA_W-3:0], adcdat_s};
            adc_cnt_r   <= CNT_ZERO;
            adc_state_r <= ADC_SHIFT;
          end
          ADC_SHIFT: begin
            adc_shift_r <= {adc_shift_r[DATA_W-3:0], adcdat_s};
            if (adc_cnt_r == ADC_LAST) begin
              adc_cnt_r   <= CNT_ZERO;
              adc_state_r <= ADC_WAIT;
            end else begin
              adc_cnt_r <= adc_cnt_r + CNT_ONE;
            end
          end
          default: begin
            adc_state_r <= ADC_WAIT;
          end
        endcase
      end
    end
  end

  // ADC holding registers, valid handshake and overrun pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      adc_l_data_r  <= {DATA_W{1'b0}};
      adc_r_data_r  <= {DATA_W{1'b0}};
      adc_l_valid_r <= 1'b0;
      adc_r_valid_r <= 1'b0;
      adc_ovr_r     <= 1'b0;
    end else begin
      if (adc_done_s && !adc_chan_r) begin
        adc_l_data_r  <= adc_word_s;
        adc_l_valid_r <= 1'b1;
      end else if (adc_l_valid_r && adc_left_ready) begin
        adc_l_valid_r <= 1'b0;
      end
      if (adc_done_s && adc_chan_r) begin
        adc_r_data_r  <= adc_word_s;
        adc_r_valid_r <= 1'b1;
      end else if (adc_r_valid_r && adc_right_ready) begin
        adc_r_valid_r <= 1'b0;
      end
      // A word consumed in the same cycle is not lost, so it is no overrun.
      adc_ovr_r <= adc_done_s & (adc_chan_r ? (adc_r_valid_r & ~adc_right_ready)
                                            : (adc_l_valid_r & ~adc_left_ready));
    end
  end

  assign adc_left_data   = adc_l_data_r;
  assign adc_right_data  = adc_r_data_r;
  assign adc_left_valid  = adc_l_valid_r;
  assign adc_right_valid = adc_r_valid_r;
  assign o_adc_overrun   = adc_ovr_r;

  // ---------------------------------------------------------------- DAC
  logic [0:0]        dac_state_r;
  logic              dac_lrck_r;
  logic [CNT_W-1:0]  dac_cnt_r;
  logic [DATA_W-1:0] dac_shift_r;
  logic [DATA_W-1:0] dac_l_hold_r, dac_r_hold_r;
  logic              dac_l_empty_r, dac_r_empty_r;
  logic              dac_dat_r, dac_und_r;
  logic              dac_edge_s, dac_l_load_s, dac_r_load_s;

  assign dac_edge_s   = bclk_fall_s & (daclrck_s ^ dac_lrck_r);
  assign dac_l_load_s = dac_edge_s & ~daclrck_s;
  assign dac_r_load_s = dac_edge_s & daclrck_s;

  // DAC holding registers; an accept in the same cycle as a load keeps the register full.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dac_l_hold_r  <= {DATA_W{1'b0}};
      dac_r_hold_r  <= {DATA_W{1'b0}};
      dac_l_empty_r <= 1'b1;
      dac_r_empty_r <= 1'b1;
    end else begin
      if (dac_left_valid && dac_l_empty_r) begin
        dac_l_hold_r  <= dac_left_data;
        dac_l_empty_r <= 1'b0;
      end else if (dac_l_load_s) begin
        dac_l_empty_r <= 1'b1;
      end
      if (dac_right_valid && dac_r_empty_r) begin
        dac_r_hold_r  <= dac_right_data;
        dac_r_empty_r <= 1'b0;
      end else if (dac_r_load_s) begin
        dac_r_empty_r <= 1'b1;
      end
    end
  end

  // DAC playback FSM; the frame-edge fall loads, later falls present MSB first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dac_state_r <= DAC_IDLE;
      dac_lrck_r  <= daclrck_s;
      dac_cnt_r   <= CNT_ZERO;
      dac_shift_r <= {DATA_W{1'b0}};
      dac_dat_r   <= 1'b0;
      dac_und_r   <= 1'b0;
    end else begin
      dac_und_r <= 1'b0;
      if (bclk_fall_s) begin
        dac_lrck_r <= daclrck_s;
      end
      if (dac_edge_s) begin
        if (daclrck_s) begin
          dac_shift_r <= dac_r_empty_r ? {DATA_W{1'b0}} : dac_r_hold_r;
          dac_und_r   <= dac_r_empty_r;
        end else begin
          dac_shift_r <= dac_l_empty_r ? {DATA_W{1'b0}} : dac_l_hold_r;
          dac_und_r   <= dac_l_empty_r;
        end
        dac_cnt_r   <= CNT_ZERO;
        dac_dat_r   <= 1'b0;
        dac_state_r <= DAC_SHIFT;
      end else if (bclk_fall_s) begin
        case (dac_state_r)
          DAC_IDLE: begin
            dac_dat_r <= 1'b0;
          end
          DAC_SHIFT: begin
            if (dac_cnt_r == DAC_LAST) begin
              dac_dat_r   <= 1'b0;
              dac_cnt_r   <= CNT_ZERO;
              dac_state_r <= DAC_IDLE;
            end else begin
              dac_dat_r   <= dac_shift_r[DATA_W-1];
              dac_shift_r <= {dac_shift_r[DATA_W-2:0], 1'b0};
              dac_cnt_r   <= dac_cnt_r + CNT_ONE;
            end
          end
          default: begin
            dac_state_r <= DAC_IDLE;
          end
        endcase
      end
    end
  end

  assign dac_left_ready  = dac_l_empty_r;
  assign dac_right_ready = dac_r_empty_r;
  assign o_AUD_DACDAT    = dac_dat_r;
  assign o_dac_underrun  = dac_und_r;

endmodule

// File: tb/tb_audio_codec_i2s.sv
// Bench for audio_codec_i2s: the bench plays an I2S codec (BCLK period 12
// system clocks, 20 BCLKs per channel slot, MSB one BCLK after each LRCK edge).
module tb_audio_codec_i2s;
  localparam int DW   = 16;
  localparam int HALF = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bclk = 1'b1, adclrck = 1'b1, daclrck = 1'b1, adcdat = 1'b0;
  logic          o_AUD_DACDAT;
  logic [DW-1:0] adc_left_data, adc_right_data;
  logic          adc_left_valid, adc_right_valid;
  logic          adc_left_ready = 1'b1, adc_right_ready = 1'b1;
  logic [DW-1:0] dac_left_data = '0, dac_right_data = '0;
  logic          dac_left_valid = 1'b0, dac_right_valid = 1'b0;
  logic          dac_left_ready, dac_right_ready;
  logic          o_adc_overrun, o_dac_underrun;

  audio_codec_i2s #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(adclrck),
    .i_AUD_DACLRCK(daclrck), .i_AUD_ADCDAT(adcdat), .o_AUD_DACDAT(o_AUD_DACDAT),
    .adc_left_data(adc_left_data), .adc_right_data(adc_right_data),
    .adc_left_valid(adc_left_valid), .adc_right_valid(adc_right_valid),
    .adc_left_ready(adc_left_ready), .adc_right_ready(adc_right_ready),
    .dac_left_data(dac_left_data), .dac_right_data(dac_right_data),
    .dac_left_valid(dac_left_valid), .dac_right_valid(dac_right_valid),
    .dac_left_ready(dac_left_ready), .dac_right_ready(dac_right_ready),
    .o_adc_overrun(o_adc_overrun), .o_dac_underrun(o_dac_underrun));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake / event monitor, sampling what the DUT flops see at the edge.
  int l_cnt = 0, r_cnt = 0, ovr_cnt = 0, und_cnt = 0, lv_cyc = 0, rv_cyc = 0;
  logic [DW-1:0] l_last = '0, r_last = '0;
  always @(posedge clk) begin
    if (adc_left_valid) lv_cyc++;
    if (adc_right_valid) rv_cyc++;
    if (adc_left_valid && adc_left_ready) begin l_cnt++; l_last = adc_left_data; end
    if (adc_right_valid && adc_right_ready) begin r_cnt++; r_last = adc_right_data; end
    if (o_adc_overrun) ovr_cnt++;
    if (o_dac_underrun) und_cnt++;
  end

  logic [DW-1:0] dac_cap;
  logic          dac_tail;

  // One BCLK period: fall (LRCK/ADCDAT change), codec samples DACDAT, rise.
  task automatic bclk_bit(input logic alr, input logic dlr, input logic dbit, input int idx);
    @(negedge clk);
    bclk = 1'b0; adclrck = alr; daclrck = dlr; adcdat = dbit;
    repeat (HALF) @(negedge clk);
    if (idx >= 1 && idx <= DW) dac_cap[DW-idx] = o_AUD_DACDAT;
    else if (o_AUD_DACDAT) dac_tail = 1'b1;
    bclk = 1'b1;
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic slot(input logic alr, input logic dlr, input logic [DW-1:0] w, input int nb);
    logic b;
    dac_cap  = '0;
    dac_tail = 1'b0;
    for (int i = 0; i < nb; i++) begin
      b = (i >= 1 && i <= DW) ? w[DW-i] : 1'b0;
      bclk_bit(alr, dlr, b, i);
    end
  endtask

  task automatic dac_push(input logic ch, input logic [DW-1:0] w);
    int n = 0;
    while ((ch ? dac_right_ready : dac_left_ready) !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    check($sformatf("push_ready_ch%0d", ch), {31'd0, (ch ? dac_right_ready : dac_left_ready)}, 32'd1);
    if (ch) begin dac_right_data = w; dac_right_valid = 1'b1; end
    else    begin dac_left_data  = w; dac_left_valid  = 1'b1; end
    @(negedge clk);
    dac_left_valid = 1'b0; dac_right_valid = 1'b0;
    check($sformatf("push_taken_ch%0d", ch), {31'd0, (ch ? dac_right_ready : dac_left_ready)}, 32'd0);
  endtask

  typedef struct {
    logic          lr;
    logic [DW-1:0] adc_w;
    logic          load;
    logic [DW-1:0] dac_w;
    logic [DW-1:0] exp_dac;
    int            exp_und;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc, rc, uc, oc, lvc, rvc;
    vecs[0] = '{1'b0, 16'hA5C3, 1'b1, 16'h8001, 16'h8001, 0};
    vecs[1] = '{1'b1, 16'h5A3C, 1'b1, 16'h7FFE, 16'h7FFE, 0};
    vecs[2] = '{1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1};
    vecs[3] = '{1'b1, 16'h0001, 1'b1, 16'h8000, 16'h8000, 0};
    vecs[4] = '{1'b0, 16'h8000, 1'b1, 16'hFFFF, 16'hFFFF, 0};
    vecs[5] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1};

    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_adc_l_valid", {31'd0, adc_left_valid}, 32'd0);
    check("rst_adc_r_valid", {31'd0, adc_right_valid}, 32'd0);
    check("rst_dac_l_ready", {31'd0, dac_left_ready}, 32'd1);
    check("rst_dac_r_ready", {31'd0, dac_right_ready}, 32'd1);
    check("rst_dacdat", {31'd0, o_AUD_DACDAT}, 32'd0);
    check("rst_pulses", {30'd0, o_adc_overrun, o_dac_underrun}, 32'd0);
    for (int i = 0; i < 3; i++) bclk_bit(1'b1, 1'b1, 1'b0, 99);

    // Table: one channel slot per vector.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].load) dac_push(vecs[i].lr, vecs[i].dac_w);
      lc = l_cnt; rc = r_cnt; uc = und_cnt; oc = ovr_cnt; lvc = lv_cyc; rvc = rv_cyc;
      slot(vecs[i].lr, vecs[i].lr, vecs[i].adc_w, 20);
      check($sformatf("vec%0d_adc_data", i), {16'd0, (vecs[i].lr ? r_last : l_last)}, {16'd0, vecs[i].adc_w});
      check($sformatf("vec%0d_adc_words", i), vecs[i].lr ? (r_cnt - rc) : (l_cnt - lc), 32'd1);
      check($sformatf("vec%0d_other_words", i), vecs[i].lr ? (l_cnt - lc) : (r_cnt - rc), 32'd0);
      check($sformatf("vec%0d_valid_cycles", i), vecs[i].lr ? (rv_cyc - rvc) : (lv_cyc - lvc), 32'd1);
      check($sformatf("vec%0d_dac_word", i), {16'd0, dac_cap}, {16'd0, vecs[i].exp_dac});
      check($sformatf("vec%0d_dac_tail", i), {31'd0, dac_tail}, 32'd0);
      check($sformatf("vec%0d_underrun", i), und_cnt - uc, vecs[i].exp_und);
      check($sformatf("vec%0d_overrun", i), ovr_cnt - oc, 32'd0);
      check($sformatf("vec%0d_dac_readys", i), {30'd0, dac_left_ready, dac_right_ready}, 32'd3);
    end

    // Overrun: right channel stalled across two right frames.
    adc_right_ready = 1'b0;
    oc = ovr_cnt; rc = r_cnt;
    slot(1'b0, 1'b0, 16'h0F0F, 20);
    slot(1'b1, 1'b1, 16'h1111, 20);
    slot(1'b0, 1'b0, 16'hF0F0, 20);
    slot(1'b1, 1'b1, 16'h2222, 20);
    @(negedge clk);
    check("ovr_pulses", ovr_cnt - oc, 32'd1);
    check("ovr_valid", {31'd0, adc_right_valid}, 32'd1);
    check("ovr_data", {16'd0, adc_right_data}, 32'h2222);
    check("ovr_no_accept", r_cnt - rc, 32'd0);
    adc_right_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr_drain_cnt", r_cnt - rc, 32'd1);
    check("ovr_drain_data", {16'd0, r_last}, 32'h2222);
    check("ovr_drain_valid", {31'd0, adc_right_valid}, 32'd0);

    // Abort: ADCLRCK toggles after 8 left bits.
    lc = l_cnt; rc = r_cnt;
    slot(1'b0, 1'b0, 16'hC3C3, 9);
    slot(1'b1, 1'b1, 16'h5AA5, 20);
    check("abort_left_none", l_cnt - lc, 32'd0);
    check("abort_right_cnt", r_cnt - rc, 32'd1);
    check("abort_right_data", {16'd0, r_last}, 32'h5AA5);
    slot(1'b0, 1'b0, 16'h1357, 20);
    check("abort_next_cnt", l_cnt - lc, 32'd1);
    check("abort_next_data", {16'd0, l_last}, 32'h1357);

    // Reset in the middle of a right slot on both paths.
    dac_push(1'b1, 16'hF0F0);
    lc = l_cnt; rc = r_cnt;
    slot(1'b1, 1'b1, 16'hDEAD, 10);
    check("pre_rst_dacdat", {31'd0, o_AUD_DACDAT}, 32'd1);
    dac_push(1'b0, 16'h0F0F);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valids", {30'd0, adc_left_valid, adc_right_valid}, 32'd0);
    check("mid_rst_readys", {30'd0, dac_left_ready, dac_right_ready}, 32'd3);
    check("mid_rst_dacdat", {31'd0, o_AUD_DACDAT}, 32'd0);
    check("mid_rst_pulses", {30'd0, o_adc_overrun, o_dac_underrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dac_push(1'b0, 16'h4321);
    uc = und_cnt;
    slot(1'b0, 1'b0, 16'h2468, 20);
    check("post_rst_right_none", r_cnt - rc, 32'd0);
    check("post_rst_adc_cnt", l_cnt - lc, 32'd1);
    check("post_rst_adc_data", {16'd0, l_last}, 32'h2468);
    check("post_rst_dac_word", {16'd0, dac_cap}, 32'h4321);
    check("post_rst_dac_tail", {31'd0, dac_tail}, 32'd0);
    check("post_rst_underrun", und_cnt - uc, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
